// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if
//  Bundles the signals between the VGA timing generator, the pixel logic
//  that colours each pixel, and the VGA DAC pins.
//  master : the timing generator. It drives the coordinates, the flags, the
//           pixel enable, the frame tick and the DAC pins, and it reads
//           pixel_color.
//  slave  : the pixel logic or the bench. It drives pixel_color and reads
//           everything else.
//  Signals:
//   pixel_color [11:0]  colour for the current X_pix/Y_pix, {B,G,R}
//   X_pix/Y_pix [9:0]   raster counters
//   H_visible/V_visible counter is inside the visible area
//   pixel_clk           one-in-two pixel enable
//   frame_start         single-cycle tick when the raster wraps to (0,0)
//   VGA_R/G/B [3:0]     colour to the DAC
//   VGA_HS/VGA_VS       sync pins
interface vga_timing_gen_if;
    logic [11:0] pixel_color;
    logic [9:0]  X_pix;
    logic [9:0]  Y_pix;
    logic        H_visible;
    logic        V_visible;
    logic        pixel_clk;
    logic        frame_start;
    logic [3:0]  VGA_R;
    logic [3:0]  VGA_G;
    logic [3:0]  VGA_B;
    logic        VGA_HS;
    logic        VGA_VS;

    modport master (
        input  pixel_color,
        output X_pix, Y_pix, H_visible, V_visible, pixel_clk, frame_start,
        output VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS
    );

    modport slave (
        output pixel_color,
        input  X_pix, Y_pix, H_visible, V_visible, pixel_clk, frame_start,
        input  VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS
    );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//  Generates 640x480@60Hz VGA timing from the 50 MHz clock. The design uses
//  a one-in-two pixel enable, so the pixel rate is 25 MHz. It publishes the
//  raster position to the pixel logic. It samples the returned colour one
//  pixel later and drives the DAC and sync pins from the same register
//  stage, which keeps colour and sync aligned.
//  Ports:
//   CLOCK_50  in  50 MHz clock, the only clock
//   reset_n   in  asynchronous active-low reset
//   vga       master modport of vga_timing_gen_if (see that file)
module vga_timing_gen #(
    parameter int   H_VIS    = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_VIS    = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic                    CLOCK_50,
    input  logic                    reset_n,
    vga_timing_gen_if.master        vga
);

    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    // The 10-bit counters cannot represent a longer raster.
    if (H_TOTAL > 1024) begin : g_h_total_chk
        $error("vga_timing_gen: horizontal total exceeds 1024");
    end
    if (V_TOTAL > 1024) begin : g_v_total_chk
        $error("vga_timing_gen: vertical total exceeds 1024");
    end

    localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS_L   = 10'(H_VIS);
    localparam logic [9:0] V_VIS_L   = 10'(V_VIS);
    localparam logic [9:0] H_SYNC_LO = 10'(H_VIS + H_FP);
    localparam logic [9:0] H_SYNC_HI = 10'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0] V_SYNC_LO = 10'(V_VIS + V_FP);
    localparam logic [9:0] V_SYNC_HI = 10'(V_VIS + V_FP + V_SYNC);

    // The window is half-open: lo is included and hi_excl is excluded.
    function automatic logic in_window(input logic [9:0] v,
                                       input logic [9:0] lo,
                                       input logic [9:0] hi_excl);
        return (v >= lo) && (v < hi_excl);
    endfunction

    logic        toggle_q,      toggle_d;
    logic        pixel_clk_q,   pixel_clk_d;
    logic [9:0]  x_q,           x_d;
    logic [9:0]  y_q,           y_d;
    logic        h_vis_q,       h_vis_d;
    logic        v_vis_q,       v_vis_d;
    logic        frame_start_q, frame_start_d;
    logic [11:0] rgb_q,         rgb_d;   // {B,G,R}, same packing as pixel_color
    logic        hs_q,          hs_d;
    logic        vs_q,          vs_d;

    // Next-state logic for the enable, the raster counters and the output stage.
    always_comb begin
        toggle_d      = ~toggle_q;
        pixel_clk_d   = toggle_q;
        x_d           = x_q;
        y_d           = y_q;
        h_vis_d       = h_vis_q;
        v_vis_d       = v_vis_q;
        frame_start_d = 1'b0;
        rgb_d         = rgb_q;
        hs_d          = hs_q;
        vs_d          = vs_q;
        if (pixel_clk_q) begin
            if (x_q == H_LAST) begin
                x_d = 10'd0;
                if (y_q == V_LAST) begin
                    y_d = 10'd0;
                end else begin
                    y_d = y_q + 10'd1;
                end
            end else begin
                x_d = x_q + 10'd1;
            end
            // The flags are computed from the new counter values, so the flag registers always agree with X_pix/Y_pix.
            h_vis_d       = (x_d < H_VIS_L);
            v_vis_d       = (y_d < V_VIS_L);
            frame_start_d = (x_q == H_LAST) && (y_q == V_LAST);
            // The colour and sync registers describe the pixel being left. h_vis_q/v_vis_q belong to that pixel.
            if (h_vis_q && v_vis_q) begin
                rgb_d = vga.pixel_color;
            end else begin
                rgb_d = 12'h000;
            end
            hs_d = in_window(x_q, H_SYNC_LO, H_SYNC_HI) ? SYNC_POL : ~SYNC_POL;
            vs_d = in_window(y_q, V_SYNC_LO, V_SYNC_HI) ? SYNC_POL : ~SYNC_POL;
        end else begin
            frame_start_d = 1'b0;
        end
    end

    // State and output registers. An asynchronous reset restarts the raster at (0,0).
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            toggle_q      <= 1'b0;
            pixel_clk_q   <= 1'b0;
            x_q           <= 10'd0;
            y_q           <= 10'd0;
            h_vis_q       <= 1'b1;
            v_vis_q       <= 1'b1;
            frame_start_q <= 1'b0;
            rgb_q         <= 12'h000;
            hs_q          <= ~SYNC_POL;
            vs_q          <= ~SYNC_POL;
        end else begin
            toggle_q      <= toggle_d;
            pixel_clk_q   <= pixel_clk_d;
            x_q           <= x_d;
            y_q           <= y_d;
            h_vis_q       <= h_vis_d;
            v_vis_q       <= v_vis_d;
            frame_start_q <= frame_start_d;
            rgb_q         <= rgb_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
        end
    end

    assign vga.X_pix       = x_q;
    assign vga.Y_pix       = y_q;
    assign vga.H_visible   = h_vis_q;
    assign vga.V_visible   = v_vis_q;
    assign vga.pixel_clk   = pixel_clk_q;
    assign vga.frame_start = frame_start_q;
    assign vga.VGA_B       = rgb_q[11:8];
    assign vga.VGA_G       = rgb_q[7:4];
    assign vga.VGA_R       = rgb_q[3:0];
    assign vga.VGA_HS      = hs_q;
    assign vga.VGA_VS      = vs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen
//  Directed bench for vga_timing_gen. Instance A uses the 640x480 timing
//  and covers the line-level behaviour and the mid-frame reset. Instance B
//  uses a shrunken raster (16x11 total) so that whole-frame behaviour fits
//  in a few hundred cycles.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst_a_n = 1'b0;
    logic rst_b_n = 1'b0;
    logic sel = 1'b0;            // 0: observe instance A, 1: observe instance B
    logic col_mode = 1'b0;       // 0: constant colour, 1: single-pixel pattern
    logic [11:0] pix_col = 12'hF00;
    int cyc = 0;
    int n_vec = 0;
    int n_miss = 0;

    vga_timing_gen_if ifa ();
    vga_timing_gen_if ifb ();

    vga_timing_gen dut_a (
        .CLOCK_50 (clk),
        .reset_n  (rst_a_n),
        .vga      (ifa)
    );

    vga_timing_gen #(
        .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_VIS(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .SYNC_POL(1'b0)
    ) dut_b (
        .CLOCK_50 (clk),
        .reset_n  (rst_b_n),
        .vga      (ifb)
    );

    // Pattern 1 lights pixel (320,3) with pure red and leaves every other pixel black.
    assign ifa.pixel_color = (col_mode == 1'b0) ? pix_col :
                             ((ifa.X_pix == 10'd320 && ifa.Y_pix == 10'd3) ? 12'h00F : 12'h000);
    assign ifb.pixel_color = pix_col;

    always #10 clk = ~clk;

    // Counts posedges to timestamp the samples taken on the following negedge.
    always @(posedge clk) cyc <= cyc + 1;

    logic [9:0]  s_x, s_y;
    logic        s_hv, s_vv, s_pclk, s_fs, s_hs, s_vs;
    logic [11:0] s_rgb;
    assign s_x    = sel ? ifb.X_pix       : ifa.X_pix;
    assign s_y    = sel ? ifb.Y_pix       : ifa.Y_pix;
    assign s_hv   = sel ? ifb.H_visible   : ifa.H_visible;
    assign s_vv   = sel ? ifb.V_visible   : ifa.V_visible;
    assign s_pclk = sel ? ifb.pixel_clk   : ifa.pixel_clk;
    assign s_fs   = sel ? ifb.frame_start : ifa.frame_start;
    assign s_hs   = sel ? ifb.VGA_HS      : ifa.VGA_HS;
    assign s_vs   = sel ? ifb.VGA_VS      : ifa.VGA_VS;
    assign s_rgb  = sel ? {ifb.VGA_B, ifb.VGA_G, ifb.VGA_R} : {ifa.VGA_B, ifa.VGA_G, ifa.VGA_R};

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check_vec({tag, "_x"},    32'(s_x),    32'd0);
        check_vec({tag, "_y"},    32'(s_y),    32'd0);
        check_vec({tag, "_pclk"}, 32'(s_pclk), 32'd0);
        check_vec({tag, "_fs"},   32'(s_fs),   32'd0);
        check_vec({tag, "_hvis"}, 32'(s_hv),   32'd1);
        check_vec({tag, "_vvis"}, 32'(s_vv),   32'd1);
        check_vec({tag, "_hs"},   32'(s_hs),   32'd1);
        check_vec({tag, "_vs"},   32'(s_vs),   32'd1);
        check_vec({tag, "_rgb"},  32'(s_rgb),  32'h000);
    endtask

    // Stops on the first negedge sample that shows (x,y).
    task automatic wait_xy(input int x, input int y, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (s_x == 10'(x) && s_y == 10'(y)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Checks the first four cycles after reset is released (expected pixel_clk 0,1,0,1; X_pix 0,0,1,1).
    task automatic check_startup(input string tag);
        logic [3:0] exp_pclk;
        logic [3:0] exp_x;
        exp_pclk = 4'b1010;
        exp_x    = 4'b1100;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_vec($sformatf("%s_pclk%0d", tag, i), 32'(s_pclk), 32'(exp_pclk[i]));
            check_vec($sformatf("%s_x%0d", tag, i),    32'(s_x),    32'(exp_x[i]));
            check_vec($sformatf("%s_y%0d", tag, i),    32'(s_y),    32'd0);
            check_vec($sformatf("%s_hs%0d", tag, i),   32'(s_hs),   32'd1);
            check_vec($sformatf("%s_vs%0d", tag, i),   32'(s_vs),   32'd1);
        end
    endtask

    initial begin
        bit ok;
        int t0, t1, k, n_low, first_on, n_on;
        int vs_low, hs_low, rgb_on, blank_err, vvis_err, fs_hi, y_first, y_last;

        // ---- reset state, instance A ----
        repeat (2) @(negedge clk);
        check_reset_vals("rst");
        rst_a_n = 1'b1;
        rst_b_n = 1'b1;
        check_startup("start");

        // ---- visible area and horizontal blanking, line 0 ----
        wait_xy(300, 0, 2000, ok);
        check_vec("tmo_x300", 32'(ok), 32'd1);
        check_vec("rgb_vis", 32'(s_rgb), 32'hF00);
        check_vec("hvis_300", 32'(s_hv), 32'd1);
        check_vec("vvis_300", 32'(s_vv), 32'd1);
        wait_xy(640, 0, 2000, ok);
        check_vec("tmo_x640", 32'(ok), 32'd1);
        check_vec("hvis_640", 32'(s_hv), 32'd0);
        check_vec("rgb_639", 32'(s_rgb), 32'hF00);
        wait_xy(641, 0, 10, ok);
        check_vec("tmo_x641", 32'(ok), 32'd1);
        check_vec("rgb_640_blank", 32'(s_rgb), 32'h000);

        // ---- horizontal sync placement and width ----
        wait_xy(656, 0, 100, ok);
        check_vec("tmo_x656", 32'(ok), 32'd1);
        k = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            k++;
            if (s_hs == 1'b0) break;
        end
        check_vec("hs_delay", 32'(k), 32'd2);
        n_low = 1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (s_hs != 1'b0) break;
            n_low++;
        end
        check_vec("hs_width", 32'(n_low), 32'd192);
        check_vec("rgb_hblank", 32'(s_rgb), 32'h000);

        // ---- line period ----
        wait_xy(0, 1, 2000, ok);
        check_vec("tmo_line1", 32'(ok), 32'd1);
        t0 = cyc;
        check_vec("hvis_line1", 32'(s_hv), 32'd1);
        wait_xy(0, 2, 2000, ok);
        check_vec("tmo_line2", 32'(ok), 32'd1);
        t1 = cyc;
        check_vec("line_period", 32'(t1 - t0), 32'd1600);

        // ---- single red pixel at (320,3) ----
        col_mode = 1'b1;
        wait_xy(320, 3, 4000, ok);
        check_vec("tmo_x320", 32'(ok), 32'd1);
        first_on = 0;
        n_on = 0;
        for (int j = 1; j <= 8; j++) begin
            @(negedge clk);
            if (s_rgb == 12'h00F) begin
                if (first_on == 0) first_on = j;
                n_on++;
            end
        end
        check_vec("dot_latency", 32'(first_on), 32'd2);
        check_vec("dot_width", 32'(n_on), 32'd2);
        col_mode = 1'b0;

        // ---- asynchronous reset mid-line ----
        wait_xy(400, 4, 4000, ok);
        check_vec("tmo_x400", 32'(ok), 32'd1);
        check_vec("rgb_pre_rst", 32'(s_rgb), 32'hF00);
        rst_a_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        @(negedge clk);
        check_vec("midrst_hold_x", 32'(s_x), 32'd0);
        rst_a_n = 1'b1;
        check_startup("restart");

        // ---- whole frame on the small raster ----
        sel = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (s_fs == 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        check_vec("tmo_fs_a", 32'(ok), 32'd1);
        t0 = cyc;
        check_vec("fs_x", 32'(s_x), 32'd0);
        check_vec("fs_y", 32'(s_y), 32'd0);
        vs_low = 0; hs_low = 0; rgb_on = 0; blank_err = 0; vvis_err = 0;
        fs_hi = 1; y_first = -1; y_last = -1;
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (s_vs == 1'b0) begin
                vs_low++;
                if (y_first < 0) y_first = int'(s_y);
                y_last = int'(s_y);
            end
            if (s_hs == 1'b0) hs_low++;
            if (s_rgb != 12'h000) rgb_on++;
            if (s_y >= 10'd7 && s_rgb != 12'h000) blank_err++;
            if (s_y == 10'd6 && s_vv != 1'b0) vvis_err++;
            if (s_y == 10'd5 && s_vv != 1'b1) vvis_err++;
            @(negedge clk);
            if (s_fs == 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        check_vec("tmo_fs_b", 32'(ok), 32'd1);
        check_vec("frame_period", 32'(cyc - t0), 32'd352);
        check_vec("fs_one_cycle", 32'(fs_hi), 32'd1);
        check_vec("vs_width", 32'(vs_low), 32'd64);
        check_vec("vs_first_line", 32'(y_first), 32'd7);
        check_vec("vs_last_line", 32'(y_last), 32'd9);
        check_vec("hs_per_frame", 32'(hs_low), 32'd66);
        check_vec("rgb_on_count", 32'(rgb_on), 32'd96);
        check_vec("vblank_rgb", 32'(blank_err), 32'd0);
        check_vec("vvis_flag", 32'(vvis_err), 32'd0);
        @(negedge clk);
        check_vec("fs_clear", 32'(s_fs), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
